shift_unit_seq: RTL and testbench

- Parametrised, multi-cycle logarithmic shifter for the ALU/execute path.
- Supports logical left, logical right, arithmetic right and rotate-left shifts.
- Processes one shift-amount bit per cycle, in the order 1, 2, 4, ... 2^(SHAMT_W-1).
- Uses valid/ready handshakes on both input and output so the pipeline can stall it.

---
 rtl/shift_unit_seq.sv | 60 ++++++
 tb/tb_shift_unit_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle logarithmic shifter (SLL/SRL/SRA/ROL), one shift-amount bit per cycle.
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy
);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
    logic [1:0]         state, md;
    logic [WIDTH-1:0]   work, next_v, sll_v, srl_v, sra_v, rol_v;
    logic [SHAMT_W-1:0] sh, k, amt;
    logic               last;
    // sh is consumed LSB-first, so sh[0] is always the bit for the current stage
    assign amt    = SHAMT_W'(1) << k;
    assign sll_v  = work << amt;
    assign srl_v  = work >> amt;
    assign sra_v  = $signed(work) >>> amt;
    assign rol_v  = (work << amt) | (work >> (WIDTH - int'(amt)));
    assign next_v = !sh[0] ? work : md == 2'b00 ? sll_v : md == 2'b01 ? srl_v : md == 2'b10 ? sra_v : rol_v;
    assign last   = k == SHAMT_W'(SHAMT_W - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            work     <= '0;
            sh       <= '0;
            md       <= '0;
            k        <= '0;
            data_out <= '0;
        end else if (state == IDLE && in_valid) begin
            work  <= data_in;
            sh    <= shamt;
            md    <= mode;
            k     <= '0;
            state <= SHIFT;
        end else if (state == SHIFT) begin
            work <= next_v;
            sh   <= sh >> 1;
            k    <= k + 1'b1;
            if (last) begin
                state    <= DONE;
                data_out <= next_v;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed and randomised scoreboard checks of shift_unit_seq at WIDTH=32 and WIDTH=8.
module tb_shift_unit_seq;
    localparam int N = 1000;
    logic        clock = 1'b0, reset = 1'b1;
    logic        iv = 1'b0, ir, ov, ordy = 1'b0, bz;
    logic [31:0] din = '0, dout;
    logic [4:0]  sa = '0;
    logic [1:0]  md = '0;
    logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b0, bz8;
    logic [7:0]  din8 = '0, dout8;
    logic [2:0]  sa8 = '0;
    logic [1:0]  md8 = '0;
    int          total = 0, passed = 0;
    logic [31:0] sb[$];

    shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) u32 (
        .clock(clock), .reset(reset), .in_valid(iv), .in_ready(ir), .data_in(din), .shamt(sa),
        .mode(md), .out_valid(ov), .out_ready(ordy), .data_out(dout), .busy(bz));
    shift_unit_seq #(.WIDTH(8), .SHAMT_W(3)) u8 (
        .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8), .data_in(din8), .shamt(sa8),
        .mode(md8), .out_valid(ov8), .out_ready(ordy8), .data_out(dout8), .busy(bz8));

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // bit-by-bit reference, independent of the shifter structure
    function automatic logic [31:0] gold(input logic [31:0] d, input int s, input logic [1:0] m, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++)
            case (m)
                2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
                2'b01:   r[i] = (i + s < w) ? d[i+s] : 1'b0;
                2'b10:   r[i] = (i + s < w) ? d[i+s] : d[w-1];
                default: r[i] = d[(i - s + w) % w];
            endcase
        return r;
    endfunction

    task automatic op32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                        input logic [31:0] exp, input string tag);
        int n = 0;
        while (!ir && n < 20) begin step(); n++; end
        check({tag, " in_ready"}, 32'(ir), 1);
        din = d; sa = s; md = m; iv = 1'b1; ordy = 1'b1;
        sb.push_back(exp);
        step();
        iv = 1'b0; din = $urandom; sa = 5'($urandom); md = 2'($urandom);
        n = 0;
        while (!ov && n < 20) begin step(); n++; end
        check({tag, " latency"}, n, 5);
        check({tag, " data"}, dout, sb.pop_front());
        step();
        check({tag, " out_valid clear"}, 32'(ov), 0);
        check({tag, " in_ready after"}, 32'(ir), 1);
    endtask

    task automatic sweep(input int w);
        int          sent = 0, recv = 0, cyc = 0, s;
        logic        hold = 1'b0, rdy, v, o, go;
        logic [31:0] held = '0, d, q;
        logic [1:0]  m;
        while (recv < N && cyc < 60000) begin
            rdy = (w == 32) ? ir : ir8;
            v   = (w == 32) ? ov : ov8;
            q   = (w == 32) ? dout : 32'(dout8);
            if (hold) begin
                check("stall valid", 32'(v), 1);
                check("stall data", q, held);
            end
            d  = (w == 32) ? $urandom : ($urandom & 32'hFF);
            s  = $urandom_range(0, w - 1);
            m  = 2'($urandom);
            go = (sent < N) && ($urandom_range(0, 1) == 1);
            o  = $urandom_range(0, 3) != 0;
            if (w == 32) begin iv = go; din = d; sa = 5'(s); md = m; ordy = o; end
            else begin iv8 = go; din8 = d[7:0]; sa8 = 3'(s); md8 = m; ordy8 = o; end
            if (go && rdy) begin sb.push_back(gold(d, s, m, w)); sent++; end
            if (v && o) begin
                check("result expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check("sweep data", q, sb.pop_front());
                recv++;
            end
            hold = v && !o;
            held = q;
            step();
            cyc++;
        end
        iv = 1'b0; iv8 = 1'b0; ordy = 1'b0; ordy8 = 1'b0;
        check("sweep received", recv, N);
        check("sweep sent", sent, N);
        check("sweep queue empty", sb.size(), 0);
    endtask

    initial begin
        int  n;
        logic seen;
        #1;
        check("reset in_ready", 32'(ir), 1);
        check("reset out_valid", 32'(ov), 0);
        check("reset busy", 32'(bz), 0);
        check("reset data_out", dout, 0);
        check("reset8 in_ready", 32'(ir8), 1);
        step(); step();
        reset = 1'b0;
        step();

        op32(32'h00000001, 5'd31, 2'b00, 32'h80000000, "sll 31");
        op32(32'h800000F0, 5'd4, 2'b10, 32'hF800000F, "sra 4");
        op32(32'h800000F0, 5'd4, 2'b01, 32'h0800000F, "srl 4");
        op32(32'h7FFFFFFF, 5'd31, 2'b10, 32'h00000000, "sra pos 31");
        op32(32'h80000001, 5'd1, 2'b11, 32'h00000003, "rol 1");
        op32(32'h80000001, 5'd0, 2'b11, 32'h80000001, "rol 0");
        op32(32'h12345678, 5'd16, 2'b11, 32'h56781234, "rol 16");

        // backpressure with an ignored second request
        ordy = 1'b0; din = 32'h0000000F; sa = 5'd8; md = 2'b00; iv = 1'b1;
        sb.push_back(32'h00000F00);
        step();
        iv = 1'b0;
        n = 0;
        while (!ov && n < 20) begin step(); n++; end
        check("bp latency", n, 5);
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", 32'(ov), 1);
            check("bp data", dout, 32'h00000F00);
            check("bp in_ready", 32'(ir), 0);
            check("bp busy", 32'(bz), 1);
            iv = (i == 3); din = 32'hDEADBEEF; sa = 5'd3; md = 2'b01;
            step();
        end
        iv = 1'b0; ordy = 1'b1;
        check("bp final data", dout, sb.pop_front());
        step();
        check("bp in_ready after", 32'(ir), 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin seen |= ov; step(); end
        check("bp second request ignored", 32'(seen), 0);

        // reset two edges after accept
        din = 32'hA5A5A5A5; sa = 5'd7; md = 2'b11; iv = 1'b1;
        sb.push_back(gold(32'hA5A5A5A5, 7, 2'b11, 32));
        step();
        iv = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("rst out_valid", 32'(ov), 0);
        check("rst in_ready", 32'(ir), 1);
        check("rst busy", 32'(bz), 0);
        check("rst data_out", dout, 0);
        sb.delete();
        #2 reset = 1'b0;
        step();
        op32(32'hFFFFFFFF, 5'd28, 2'b01, 32'h0000000F, "srl after reset");

        ordy = 1'b0;
        sweep(32);
        sweep(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
